// File: rtl/mct_axi_mem_pkg.sv
// Shared types and geometry for the AXI4 device-memory responder.
// Localparams describe the default build; the helpers derive the same values from overrides.
package mct_axi_mem_pkg;

  localparam int unsigned MEM_DATA_WIDTH  = 512;
  localparam int unsigned MEM_DEPTH_LINES = 4096;
  localparam int unsigned LINE_BYTES      = MEM_DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH       = $clog2(MEM_DEPTH_LINES);
  localparam int unsigned ADDR_LSB        = $clog2(LINE_BYTES);

  typedef enum logic [0:0] {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_DATA = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  function automatic int unsigned idx_width_f(input int unsigned depth_lines);
    return $clog2(depth_lines);
  endfunction

  function automatic int unsigned addr_lsb_f(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mct_line_ram.sv
// Line-wide single-clock RAM: registered read port, byte-enabled write port.
// Simultaneous read and write of one line return the old contents.
module mct_line_ram #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                    ap_clk,
  input  logic                    rst_n,
  input  logic                    rd_en_i,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  input  logic                    wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Byte-masked write port; the array is never reset.
  always_ff @(posedge ap_clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be_i[b]) begin
          mem_q[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
        end
      end
    end
  end

  // Registered read port with output-register reset.
  always_ff @(posedge ap_clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mct_axi_mem_responder.sv
// AXI4 memory-side responder for the kernel m00_axi port: INCR full-line bursts,
// independent read and write engines sharing one line RAM.
module mct_axi_mem_responder
  import mct_axi_mem_pkg::*;
#(
  parameter int unsigned C_ADDR_WIDTH    = 64,
  parameter int unsigned C_DATA_WIDTH    = MEM_DATA_WIDTH,
  parameter int unsigned C_DEPTH_LINES   = MEM_DEPTH_LINES,
  parameter logic [7:0]  C_RD_STALL_MASK = 8'h00
) (
  input  logic                      ap_clk,
  input  logic                      rst_n,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                      s_axi_rlast,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic                      err_wlast,
  output logic [31:0]               rd_lines,
  output logic [31:0]               wr_lines
);

  localparam int unsigned L_IDX_W = idx_width_f(C_DEPTH_LINES);
  localparam int unsigned L_LSB   = addr_lsb_f(C_DATA_WIDTH);

  rd_state_t            rd_state_q, rd_state_d;
  logic [L_IDX_W-1:0]   rd_idx_q, rd_idx_d;
  logic [7:0]           rd_len_q, rd_len_d;
  logic [7:0]           rd_beat_q, rd_beat_d;
  logic                 rvalid_q, rvalid_d;
  logic [2:0]           stall_cnt_q;
  logic [2:0]           stall_nxt_s;
  logic                 stall_s;
  logic                 rd_hs_s;
  logic                 rd_last_s;
  logic [L_IDX_W-1:0]   ar_idx_s;
  logic [L_IDX_W-1:0]   rd_idx_inc_s;
  logic                 ram_rd_en_s;
  logic [L_IDX_W-1:0]   ram_rd_addr_s;
  logic [C_DATA_WIDTH-1:0] ram_rd_data_s;

  wr_state_t            wr_state_q, wr_state_d;
  logic [L_IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [7:0]           wr_len_q, wr_len_d;
  logic [7:0]           wr_beat_q, wr_beat_d;
  logic                 err_wlast_q, err_wlast_d;
  logic                 wr_hs_s;
  logic                 wr_last_s;
  logic                 ram_we_s;

  logic [31:0]          rd_lines_q;
  logic [31:0]          wr_lines_q;
  logic                 unused_addr_s;

  // Only the line-index slice of each address matters.
  assign unused_addr_s = ^{s_axi_araddr, s_axi_awaddr};

  assign ar_idx_s     = s_axi_araddr[L_LSB +: L_IDX_W];
  assign rd_idx_inc_s = rd_idx_q + L_IDX_W'(1);
  assign stall_nxt_s  = stall_cnt_q + 3'd1;
  assign stall_s      = C_RD_STALL_MASK[stall_nxt_s];
  assign rd_hs_s      = rvalid_q & s_axi_rready;
  assign rd_last_s    = (rd_beat_q == rd_len_q);
  assign wr_last_s    = (wr_beat_q == wr_len_q);
  assign wr_hs_s      = ram_we_s;

  mct_line_ram #(
    .DATA_WIDTH (C_DATA_WIDTH),
    .DEPTH      (C_DEPTH_LINES),
    .ADDR_WIDTH (L_IDX_W)
  ) u_ram (
    .ap_clk    (ap_clk),
    .rst_n     (rst_n),
    .rd_en_i   (ram_rd_en_s),
    .rd_addr_i (ram_rd_addr_s),
    .rd_data_o (ram_rd_data_s),
    .wr_en_i   (ram_we_s),
    .wr_addr_i (wr_idx_q),
    .wr_data_i (s_axi_wdata),
    .wr_be_i   (s_axi_wstrb)
  );

  // State and datapath registers for both engines plus counters.
  always_ff @(posedge ap_clk) begin
    if (!rst_n) begin
      rd_state_q  <= RD_IDLE;
      rd_idx_q    <= '0;
      rd_len_q    <= 8'd0;
      rd_beat_q   <= 8'd0;
      rvalid_q    <= 1'b0;
      stall_cnt_q <= 3'd0;
      wr_state_q  <= WR_IDLE;
      wr_idx_q    <= '0;
      wr_len_q    <= 8'd0;
      wr_beat_q   <= 8'd0;
      err_wlast_q <= 1'b0;
      rd_lines_q  <= 32'd0;
      wr_lines_q  <= 32'd0;
    end else begin
      rd_state_q  <= rd_state_d;
      rd_idx_q    <= rd_idx_d;
      rd_len_q    <= rd_len_d;
      rd_beat_q   <= rd_beat_d;
      rvalid_q    <= rvalid_d;
      stall_cnt_q <= stall_nxt_s;
      wr_state_q  <= wr_state_d;
      wr_idx_q    <= wr_idx_d;
      wr_len_q    <= wr_len_d;
      wr_beat_q   <= wr_beat_d;
      err_wlast_q <= err_wlast_d;
      rd_lines_q  <= rd_hs_s ? (rd_lines_q + 32'd1) : rd_lines_q;
      wr_lines_q  <= wr_hs_s ? (wr_lines_q + 32'd1) : wr_lines_q;
    end
  end

  // Read next state: a presented beat stays up until taken; stalls only gate fresh beats.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_len_d   = rd_len_q;
    rd_beat_d  = rd_beat_q;
    rvalid_d   = rvalid_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (s_axi_arvalid) begin
          rd_state_d = RD_BURST;
          rd_idx_d   = ar_idx_s;
          rd_len_d   = s_axi_arlen;
          rd_beat_d  = 8'd0;
          rvalid_d   = ~stall_s;
        end else begin
          rvalid_d   = 1'b0;
        end
      end
      RD_BURST: begin
        if (rd_hs_s) begin
          if (rd_last_s) begin
            rd_state_d = RD_IDLE;
            rvalid_d   = 1'b0;
          end else begin
            rd_idx_d   = rd_idx_inc_s;
            rd_beat_d  = rd_beat_q + 8'd1;
            rvalid_d   = ~stall_s;
          end
        end else if (!rvalid_q) begin
          rvalid_d = ~stall_s;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
        rvalid_d   = 1'b0;
      end
    endcase
  end

  // Read outputs: fetch on AR accept, prefetch next line on a non-final handshake.
  always_comb begin
    s_axi_arready = 1'b0;
    ram_rd_en_s   = 1'b0;
    ram_rd_addr_s = rd_idx_q;
    case (rd_state_q)
      RD_IDLE: begin
        s_axi_arready = 1'b1;
        if (s_axi_arvalid) begin
          ram_rd_en_s   = 1'b1;
          ram_rd_addr_s = ar_idx_s;
        end else begin
          ram_rd_en_s   = 1'b0;
        end
      end
      RD_BURST: begin
        if (rd_hs_s && !rd_last_s) begin
          ram_rd_en_s   = 1'b1;
          ram_rd_addr_s = rd_idx_inc_s;
        end else begin
          ram_rd_en_s   = 1'b0;
        end
      end
      default: begin
        s_axi_arready = 1'b0;
      end
    endcase
  end

  // Write next state: the AW beat count decides burst end, wlast is only audited.
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_idx_d    = wr_idx_q;
    wr_len_d    = wr_len_q;
    wr_beat_d   = wr_beat_q;
    err_wlast_d = err_wlast_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (s_axi_awvalid) begin
          wr_state_d = WR_DATA;
          wr_idx_d   = s_axi_awaddr[L_LSB +: L_IDX_W];
          wr_len_d   = s_axi_awlen;
          wr_beat_d  = 8'd0;
        end else begin
          wr_state_d = WR_IDLE;
        end
      end
      WR_DATA: begin
        if (s_axi_wvalid) begin
          wr_idx_d  = wr_idx_q + L_IDX_W'(1);
          wr_beat_d = wr_beat_q + 8'd1;
          if (wr_last_s) begin
            wr_state_d = WR_RESP;
          end else begin
            wr_state_d = WR_DATA;
          end
          if (s_axi_wlast != wr_last_s) begin
            err_wlast_d = 1'b1;
          end else begin
            err_wlast_d = err_wlast_q;
          end
        end else begin
          wr_state_d = WR_DATA;
        end
      end
      WR_RESP: begin
        if (s_axi_bready) begin
          wr_state_d = WR_IDLE;
        end else begin
          wr_state_d = WR_RESP;
        end
      end
      default: begin
        wr_state_d = WR_IDLE;
      end
    endcase
  end

  // Write outputs decoded from the write state.
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    ram_we_s      = 1'b0;
    case (wr_state_q)
      WR_IDLE: s_axi_awready = 1'b1;
      WR_DATA: begin
        s_axi_wready = 1'b1;
        ram_we_s     = s_axi_wvalid;
      end
      WR_RESP: s_axi_bvalid = 1'b1;
      default: s_axi_awready = 1'b0;
    endcase
  end

  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = ram_rd_data_s;
  assign s_axi_rlast  = rvalid_q & rd_last_s;
  assign err_wlast    = err_wlast_q;
  assign rd_lines     = rd_lines_q;
  assign wr_lines     = wr_lines_q;

endmodule

// File: tb/tb_mct_axi_mem_responder.sv
// Directed bench for mct_axi_mem_responder: table of read bursts plus hand-written
// write, backpressure, collision, reset and wrap sequences against a line model.
module tb_mct_axi_mem_responder;

  localparam int DW    = 512;
  localparam int DEPTH = 4096;
  localparam int BEW   = DW / 8;

  logic            ap_clk;
  logic            rst_n;
  logic            s_axi_arvalid, s_axi_arready;
  logic [63:0]     s_axi_araddr;
  logic [7:0]      s_axi_arlen;
  logic            s_axi_rvalid, s_axi_rready, s_axi_rlast;
  logic [DW-1:0]   s_axi_rdata;
  logic            s_axi_awvalid, s_axi_awready;
  logic [63:0]     s_axi_awaddr;
  logic [7:0]      s_axi_awlen;
  logic            s_axi_wvalid, s_axi_wready, s_axi_wlast;
  logic [DW-1:0]   s_axi_wdata;
  logic [BEW-1:0]  s_axi_wstrb;
  logic            s_axi_bvalid, s_axi_bready;
  logic            err_wlast;
  logic [31:0]     rd_lines, wr_lines;

  int total;
  int bad;
  int exp_rd;
  int exp_wr;

  logic [DW-1:0]  model [DEPTH];
  logic [DW-1:0]  wd_a [4];
  logic [BEW-1:0] ws_a [4];

  typedef struct {
    logic [63:0] addr;
    int          len;
    logic [31:0] rr_pat;
    logic [31:0] exp_rd_lines;
  } rd_vec_t;

  rd_vec_t rd_tab [3];

  mct_axi_mem_responder #(
    .C_ADDR_WIDTH    (64),
    .C_DATA_WIDTH    (DW),
    .C_DEPTH_LINES   (DEPTH),
    .C_RD_STALL_MASK (8'h00)
  ) dut (
    .ap_clk        (ap_clk),
    .rst_n         (rst_n),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .err_wlast     (err_wlast),
    .rd_lines      (rd_lines),
    .wr_lines      (wr_lines)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic model_write(input int idx, input logic [DW-1:0] d, input logic [BEW-1:0] s);
    for (int k = 0; k < BEW; k++) begin
      if (s[k]) model[idx][k*8 +: 8] = d[k*8 +: 8];
    end
  endtask

  task automatic rd_burst(input logic [63:0] addr, input int len, input logic [31:0] rr_pat);
    int idx;
    int beat;
    int cyc;
    int wt;
    idx = int'(addr[6 +: 12]);
    s_axi_araddr  = addr;
    s_axi_arlen   = 8'(len);
    s_axi_arvalid = 1'b1;
    wt = 0;
    while (!s_axi_arready && wt < 20) begin
      tick();
      wt++;
    end
    chk("ar_wait", DW'(s_axi_arready), DW'(1'b1));
    tick();
    s_axi_arvalid = 1'b0;
    chk("rd_first_rvalid", DW'(s_axi_rvalid), DW'(1'b1));
    beat = 0;
    cyc  = 0;
    while (beat <= len && cyc < 64) begin
      s_axi_rready = rr_pat[cyc % 32];
      if (s_axi_rvalid) begin
        chk("rdata", s_axi_rdata, model[(idx + beat) % DEPTH]);
        chk("rlast", DW'(s_axi_rlast), DW'(beat == len));
        if (s_axi_rready) begin
          beat++;
          exp_rd++;
        end
      end
      tick();
      cyc++;
    end
    s_axi_rready = 1'b0;
    chk("rd_beats", DW'(beat), DW'(len + 1));
    chk("rd_end_rvalid", DW'(s_axi_rvalid), DW'(1'b0));
    chk("rd_end_arready", DW'(s_axi_arready), DW'(1'b1));
  endtask

  task automatic wr_burst(input logic [63:0] addr, input int len, input int wlast_at, input int bdelay);
    int idx;
    int wt;
    idx = int'(addr[6 +: 12]);
    s_axi_awaddr  = addr;
    s_axi_awlen   = 8'(len);
    s_axi_awvalid = 1'b1;
    wt = 0;
    while (!s_axi_awready && wt < 20) begin
      tick();
      wt++;
    end
    chk("aw_wait", DW'(s_axi_awready), DW'(1'b1));
    tick();
    s_axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      chk("wready", DW'(s_axi_wready), DW'(1'b1));
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = wd_a[b];
      s_axi_wstrb  = ws_a[b];
      s_axi_wlast  = (b == wlast_at);
      tick();
      model_write((idx + b) % DEPTH, wd_a[b], ws_a[b]);
      exp_wr++;
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    chk("bvalid_up", DW'(s_axi_bvalid), DW'(1'b1));
    for (int d = 0; d < bdelay; d++) begin
      tick();
      chk("bvalid_hold", DW'(s_axi_bvalid), DW'(1'b1));
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    chk("bvalid_drop", DW'(s_axi_bvalid), DW'(1'b0));
    chk("awready_back", DW'(s_axi_awready), DW'(1'b1));
  endtask

  initial begin
    logic [DW-1:0] old_line;
    total = 0;
    bad = 0;
    exp_rd = 0;
    exp_wr = 0;
    rst_n = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_araddr = 64'd0; s_axi_arlen = 8'd0; s_axi_rready = 1'b0;
    s_axi_awvalid = 1'b0; s_axi_awaddr = 64'd0; s_axi_awlen = 8'd0;
    s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_bready = 1'b0;

    rd_tab[0] = '{addr: 64'h0,                  len: 7, rr_pat: 32'hFFFF_FFFF, exp_rd_lines: 32'd8};
    rd_tab[1] = '{addr: 64'hD5,                 len: 0, rr_pat: 32'hFFFF_FFFF, exp_rd_lines: 32'd9};
    rd_tab[2] = '{addr: 64'h8000_0000_0000_0280, len: 2, rr_pat: 32'hFFFF_FFFF, exp_rd_lines: 32'd12};

    tick();
    tick();
    for (int i = 0; i < 32; i++) begin
      dut.u_ram.mem_q[i] = DW'(i);
      model[i] = DW'(i);
    end
    rst_n = 1'b1;
    chk("rst_arready", DW'(s_axi_arready), DW'(1'b1));
    chk("rst_awready", DW'(s_axi_awready), DW'(1'b1));
    chk("rst_rvalid",  DW'(s_axi_rvalid),  DW'(1'b0));
    chk("rst_rlast",   DW'(s_axi_rlast),   DW'(1'b0));
    chk("rst_wready",  DW'(s_axi_wready),  DW'(1'b0));
    chk("rst_bvalid",  DW'(s_axi_bvalid),  DW'(1'b0));
    chk("rst_err",     DW'(err_wlast),     DW'(1'b0));
    chk("rst_rd_lines", DW'(rd_lines),     DW'(32'd0));
    chk("rst_wr_lines", DW'(wr_lines),     DW'(32'd0));
    chk("rst_rdata",   s_axi_rdata,        DW'(0));

    for (int v = 0; v < 3; v++) begin
      rd_burst(rd_tab[v].addr, rd_tab[v].len, rd_tab[v].rr_pat);
      chk("tab_rd_lines", DW'(rd_lines), DW'(rd_tab[v].exp_rd_lines));
    end

    // Full-line write then low-byte-only write, with a delayed bready.
    wd_a[0] = {64{8'hAA}}; ws_a[0] = {BEW{1'b1}};
    wd_a[1] = {64{8'hBB}}; ws_a[1] = 64'h1;
    wr_burst(64'h40, 1, 1, 5);
    chk("wr_lines_2", DW'(wr_lines), DW'(32'd2));
    chk("line1_bd", dut.u_ram.mem_q[1], {64{8'hAA}});
    chk("line2_bd", dut.u_ram.mem_q[2], DW'(8'hBB));
    chk("err_clean", DW'(err_wlast), DW'(1'b0));
    rd_burst(64'h40, 1, 32'hFFFF_FFFF);

    rd_burst(64'h200, 3, 32'h5555_5555);

    for (int b = 0; b < 4; b++) begin
      wd_a[b] = {16{32'(b + 100)}};
      ws_a[b] = {BEW{1'b1}};
    end
    wr_burst(64'h400, 3, 1, 0);
    chk("err_set", DW'(err_wlast), DW'(1'b1));
    chk("err_beats", DW'(wr_lines), DW'(exp_wr));
    wd_a[0] = {16{32'hCAFE_0014}};
    wr_burst(64'h500, 0, 0, 1);
    chk("err_sticky", DW'(err_wlast), DW'(1'b1));
    rd_burst(64'h400, 4, 32'hFFFF_FFFF);

    // Write and read fetch of line 5 on the same edge.
    old_line = model[5];
    s_axi_awaddr = 64'h140; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wdata = {16{32'h5EED_0005}}; s_axi_wstrb = {BEW{1'b1}}; s_axi_wlast = 1'b1;
    s_axi_araddr = 64'h140; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    tick();
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
    chk("coll_rvalid", DW'(s_axi_rvalid), DW'(1'b1));
    chk("coll_old",    s_axi_rdata, old_line);
    chk("coll_rlast",  DW'(s_axi_rlast), DW'(1'b1));
    chk("coll_bvalid", DW'(s_axi_bvalid), DW'(1'b1));
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    model_write(5, {16{32'h5EED_0005}}, {BEW{1'b1}});
    exp_rd++;
    exp_wr++;
    chk("coll_rvalid_done", DW'(s_axi_rvalid), DW'(1'b0));
    chk("coll_bvalid_done", DW'(s_axi_bvalid), DW'(1'b0));
    rd_burst(64'h140, 0, 32'hFFFF_FFFF);
    chk("rd_lines_mid", DW'(rd_lines), DW'(exp_rd));
    chk("wr_lines_mid", DW'(wr_lines), DW'(exp_wr));

    // Reset while beat 2 of an 8-beat burst is presented.
    s_axi_araddr = 64'h0; s_axi_arlen = 8'd7; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    tick();
    tick();
    chk("pre_rst_beat2", s_axi_rdata, model[2]);
    rst_n = 1'b0; s_axi_rready = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    chk("mrst_rvalid",  DW'(s_axi_rvalid),  DW'(1'b0));
    chk("mrst_arready", DW'(s_axi_arready), DW'(1'b1));
    chk("mrst_rlast",   DW'(s_axi_rlast),   DW'(1'b0));
    chk("mrst_rdata",   s_axi_rdata,        DW'(0));
    chk("mrst_err",     DW'(err_wlast),     DW'(1'b0));
    chk("mrst_rd_lines", DW'(rd_lines),     DW'(32'd0));
    rd_burst(64'hC0, 1, 32'hFFFF_FFFF);

    // Bursts starting two lines below the top wrap to lines 0 and 1.
    for (int b = 0; b < 4; b++) begin
      wd_a[b] = {16{32'(32'hF00D_0000 + b)}};
      ws_a[b] = {BEW{1'b1}};
    end
    wr_burst(64'(DEPTH - 2) * 64'd64, 3, 3, 2);
    chk("wrap_line0_bd", dut.u_ram.mem_q[0], {16{32'hF00D_0002}});
    rd_burst(64'(DEPTH - 2) * 64'd64, 3, 32'hFFFF_FFFF);
    chk("final_rd_lines", DW'(rd_lines), DW'(32'd6));
    chk("final_wr_lines", DW'(wr_lines), DW'(32'd4));
    chk("final_err", DW'(err_wlast), DW'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mct_axi_mem_responder.md
Name: mct_axi_mem_responder

Overview:
- AXI4 memory-side responder (slave) for the kernel's m00_axi master port: serves AR/R bursts and accepts AW/W/B bursts against an internal line-wide RAM.
- Used as the device-memory model in kernel-level benches and hardware emulation builds.
- Holds NFA edge lines, query lines and result lines.
- Address channel subset matches the master port exactly: no IDs, no size/burst fields, INCR bursts of full-width beats only.

Parameters:
- C_ADDR_WIDTH, 64, AXI address width.
- C_DATA_WIDTH, 512, beat width in bits; one beat = one cache line (CL).
- C_DEPTH_LINES, 4096, RAM depth in lines; power of two.
- C_RD_STALL_MASK, 0, 8-bit pattern; bit k set forces rvalid low on stall-counter value k (backpressure injection; 0 = none).

Ports:
- ap_clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_araddr  in  C_ADDR_WIDTH  read byte address
- s_axi_arlen  in  8  read beats minus one
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- s_axi_rdata  out  C_DATA_WIDTH  read data
- s_axi_rlast  out  1  last read beat
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_awaddr  in  C_ADDR_WIDTH  write byte address
- s_axi_awlen  in  8  write beats minus one
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_wdata  in  C_DATA_WIDTH  write data
- s_axi_wstrb  in  C_DATA_WIDTH/8  byte enables
- s_axi_wlast  in  1  last write beat
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- err_wlast  out  1  sticky: wlast disagreed with awlen beat count
- rd_lines  out  32  total R beats accepted since reset
- wr_lines  out  32  total W beats accepted since reset

Behaviour:
- Clock ap_clk; reset rst_n, synchronous, active-low.
- Reset values: arready=1, awready=1; rvalid, rlast, wready, bvalid, err_wlast = 0; counters = 0; rdata = 0.
- RAM contents are not cleared by reset.
- Line index = addr[log2(C_DATA_WIDTH/8) +: log2(C_DEPTH_LINES)]. Upper bits ignored; low byte-offset bits ignored (aligned addressing).
- Burst index increments per beat and wraps modulo C_DEPTH_LINES.
- Read FSM, states RD_IDLE and RD_BURST:
  - RD_IDLE: arready=1. On arvalid, latch index and arlen, load rdata<=mem[idx], go to RD_BURST; rvalid rises the next cycle (1-cycle latency).
  - RD_BURST: arready=0. On rvalid&rready: if beat==arlen go to RD_IDLE (arready=1 next cycle), else rdata<=mem[idx+1] on the same edge, so there are no bubbles.
  - rlast = rvalid & (beat==arlen).
  - rdata and rlast are held stable while rvalid&!rready.
- Stall injection: a free-running 3-bit counter; rvalid is gated low when C_RD_STALL_MASK[cnt] is set. It never deasserts a beat that is already presented (gating applies only to the cycle after a handshake or entry).
- Write FSM, states WR_IDLE, WR_DATA, WR_RESP:
  - WR_IDLE: awready=1. On awvalid, latch index and awlen, go to WR_DATA.
  - WR_DATA: wready=1. Each wvalid beat writes bytes where wstrb=1.
  - Beat count is authoritative: on beat==awlen go to WR_RESP. If wlast != (beat==awlen), set err_wlast.
  - WR_RESP: bvalid=1 until bready, then go to WR_IDLE.
- Read and write FSMs are independent and may be active simultaneously.
- Same-line read fetch and write on the same edge: read-first (old data returned).
- arlen=0 / awlen=0: single-beat burst; rlast is asserted with the first beat.
- Counters wrap at 2^32.
- Reset mid-burst: both FSMs return to idle next cycle; partial writes already committed remain.

Decomposition:
- Package mct_axi_mem_pkg: rd_state_t and wr_state_t enums, and localparams LINE_BYTES, IDX_WIDTH and ADDR_LSB derived from the parameters.
- One sub-module, mct_line_ram: a single-clock RAM with one read port (registered) and one write port with byte enables. It must infer BRAM/URAM.

Test Plan:
- Backdoor preload lines 0..7 with value = index. AR addr=0x0, len=7, rready=1 → rvalid one cycle after AR handshake; 8 consecutive beats 0..7; rlast only on beat 7; rd_lines=8.
- AW addr=0x40, len=1. W beats 0xAA.., 0xBB.. with wstrb all-ones on beat 0 and only the low byte on beat 1 → lines 1 and 2 updated accordingly; bvalid held until bready (bready delayed 5 cycles); wr_lines=2.
- rready toggled 1-0-1 during an arlen=3 burst → no beat lost or duplicated; rdata stable during stalls.
- AW len=3 with wlast asserted on beat 1 → 4 beats written, err_wlast=1 and sticky.
- Concurrent read and write of the same line at the same edge → read returns old value; a later read returns new value.
- Reset asserted mid read burst (beat 2 of 8) → next cycle rvalid=0, arready=1; a new AR is served correctly. Burst starting at line C_DEPTH_LINES-2 with len=3 → wraps to lines 0 and 1.
